// File: rtl/display_sequencer.sv
// Captures PC, x5 and controller state on update, converts both bytes to BCD serially and commits five display digits at once.
// Latency 17 clocks from the sampling edge to new digits; no backpressure, requests arriving while busy collapse into one restart. `final` is reserved in SystemVerilog, so the fifth digit port is final_digit.
module display_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update,
  input  logic [7:0] pc_in,
  input  logic [7:0] x5_in,
  input  logic [3:0] estado_in,
  output logic [3:0] pc1,
  output logic [3:0] pc2,
  output logic [3:0] x5part1,
  output logic [3:0] x5part2,
  output logic [3:0] final_digit,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, CONV_PC, CONV_X5, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  pc_q, x5_q;
  logic [3:0]  estado_q;
  logic [11:0] bcd_q;
  logic [11:0] pc_bcd_q;
  logic [2:0]  cnt_q;
  logic        pending_q;
  logic        start;
  logic        cnt_last;
  logic [7:0]  op;
  logic [11:0] bcd_adj;
  logic [19:0] sh;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step on whichever operand is being converted
  assign op       = (state == CONV_X5) ? x5_q : pc_q;
  assign bcd_adj  = {adj3(bcd_q[11:8]), adj3(bcd_q[7:4]), adj3(bcd_q[3:0])};
  assign sh       = {bcd_adj, op} << 1;
  assign cnt_last = (cnt_q == 3'd7);
  assign start    = (state == IDLE && update) || (state == COMMIT && (pending_q || update));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (update) state_nxt = CONV_PC;
      CONV_PC: if (cnt_last) state_nxt = CONV_X5;
      CONV_X5: if (cnt_last) state_nxt = COMMIT;
      COMMIT:  state_nxt = (pending_q || update) ? CONV_PC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      x5_q        <= '0;
      estado_q    <= '0;
      bcd_q       <= '0;
      pc_bcd_q    <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      pc1         <= '0;
      pc2         <= '0;
      x5part1     <= '0;
      x5part2     <= '0;
      final_digit <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && update) pending_q <= 1'b1;

      case (state)
        CONV_PC: begin
          bcd_q <= sh[19:8];
          pc_q  <= sh[7:0];
          cnt_q <= cnt_q + 3'd1;
          if (cnt_last) begin
            pc_bcd_q <= sh[19:8];
            bcd_q    <= '0;
          end
        end
        CONV_X5: begin
          bcd_q <= sh[19:8];
          x5_q  <= sh[7:0];
          cnt_q <= cnt_q + 3'd1;
        end
        COMMIT: begin
          // A value above 99 cannot be shown in two digits, so blank that pair
          pc1         <= (pc_bcd_q[11:8] != 4'd0) ? 4'hF : pc_bcd_q[7:4];
          pc2         <= (pc_bcd_q[11:8] != 4'd0) ? 4'hF : pc_bcd_q[3:0];
          x5part1     <= (bcd_q[11:8] != 4'd0) ? 4'hF : bcd_q[7:4];
          x5part2     <= (bcd_q[11:8] != 4'd0) ? 4'hF : bcd_q[3:0];
          final_digit <= (estado_q <= 4'd9) ? estado_q : 4'hF;
          done        <= 1'b1;
          pending_q   <= 1'b0;
        end
        default: ;
      endcase

      if (start) begin
        pc_q     <= pc_in;
        x5_q     <= x5_in;
        estado_q <= estado_in;
        bcd_q    <= '0;
        cnt_q    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized and directed stimulus against a cycle-timed reference model; a monitor pops expected digit sets on every done pulse.
module tb_display_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       update = 1'b0;
  logic [7:0] pc_in = '0;
  logic [7:0] x5_in = '0;
  logic [3:0] estado_in = '0;
  logic [3:0] pc1, pc2, x5part1, x5part2, final_digit;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  display_sequencer dut (
    .clk(clk), .rst_n(rst_n), .update(update), .pc_in(pc_in), .x5_in(x5_in),
    .estado_in(estado_in), .pc1(pc1), .pc2(pc2), .x5part1(x5part1), .x5part2(x5part2),
    .final_digit(final_digit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: digits of a captured request, computed straight from the display rules
  function automatic logic [19:0] digits(input int pc, input int x5, input int es);
    logic [7:0] p, x;
    logic [3:0] f;
    p = (pc > 99) ? 8'hFF : {4'(pc / 10), 4'(pc % 10)};
    x = (x5 > 99) ? 8'hFF : {4'(x5 / 10), 4'(x5 % 10)};
    f = (es > 9) ? 4'hF : 4'(es);
    return {p, x, f};
  endfunction

  // Model: a request captured at edge n commits at edge n+17; requests seen in between collapse into one restart
  int          cyc = 0;
  int          commit_at = -1;
  bit          pend = 0;
  int          c_pc, c_x5, c_es;
  logic [19:0] cur_exp = '0;
  bit          done_exp = 0;
  logic [19:0] sb_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_at = -1;
      pend      = 0;
      cur_exp   = '0;
      done_exp  = 0;
      sb_q.delete();
    end else begin
      cyc++;
      done_exp = 0;
      if (commit_at == cyc) begin
        cur_exp  = digits(c_pc, c_x5, c_es);
        sb_q.push_back(cur_exp);
        done_exp = 1;
        if (pend || update) begin
          c_pc = pc_in; c_x5 = x5_in; c_es = estado_in;
          commit_at = cyc + 17;
          pend = 0;
        end else begin
          commit_at = -1;
        end
      end else if (commit_at == -1) begin
        if (update) begin
          c_pc = pc_in; c_x5 = x5_in; c_es = estado_in;
          commit_at = cyc + 17;
        end
      end else if (update) begin
        pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("digits", {12'd0, pc1, pc2, x5part1, x5part2, final_digit}, {12'd0, cur_exp});
    chk("busy", 32'(busy), 32'(commit_at != -1));
    chk("done", 32'(done), 32'(done_exp));
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit: done pulse with no expected commit at %0t", $time);
      end else begin
        chk("commit", {12'd0, pc1, pc2, x5part1, x5part2, final_digit}, {12'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic step(input logic u, input logic [7:0] p, input logic [7:0] x, input logic [3:0] e);
    update = u; pc_in = p; x5_in = x; estado_in = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0: return 8'd99;
      1: return 8'd100;
      2: return 8'd0;
      3: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(0, 8'd0, 8'd0, 4'd0);

    // Basic conversion with inputs toggling underneath it
    step(1, 8'd42, 8'd7, 4'd6);
    repeat (20) step(0, rnd8(), rnd8(), 4'($urandom_range(0, 15)));

    // Two-digit limits and out-of-range state
    step(1, 8'd99, 8'd100, 4'd10);
    repeat (20) step(0, 8'd0, 8'd0, 4'd0);
    step(1, 8'd0, 8'd255, 4'd0);
    repeat (20) step(0, 8'd0, 8'd0, 4'd0);

    // Three requests during one conversion give exactly one restart
    step(1, 8'd200, 8'd3, 4'd9);
    for (int e = 1; e <= 20; e++)
      step(e == 5 || e == 9 || e == 12, (e >= 16) ? 8'd13 : rnd8(), (e >= 16) ? 8'd58 : rnd8(), 4'd3);
    repeat (20) step(0, 8'd13, 8'd58, 4'd3);

    // Reset in the middle of a conversion
    step(1, 8'd77, 8'd88, 4'd2);
    repeat (10) step(0, 8'd0, 8'd0, 4'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_digits", {12'd0, pc1, pc2, x5part1, x5part2, final_digit}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) step(0, 8'd0, 8'd0, 4'd0);
    rst_n = 1'b1;
    step(0, 8'd0, 8'd0, 4'd0);
    step(1, 8'd64, 8'd45, 4'd9);
    repeat (20) step(0, 8'd0, 8'd0, 4'd0);

    // Random traffic, including requests landing on commit edges
    repeat (600) step($urandom_range(0, 7) == 0, rnd8(), rnd8(), 4'($urandom_range(0, 15)));
    repeat (40) step(0, 8'd0, 8'd0, 4'd0);

    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
